// File: rtl/nano_cpu_gen_pkg.sv
// Shared definitions for the nano CPU: opcode and FSM state encodings,
// instruction field positions and a small decode helper.
package nano_cpu_gen_pkg;

  // Instruction opcodes, IR[15:12]. Codes D..F all decode as END.
  typedef enum logic [3:0] {
    OP_READ   = 4'h0,
    OP_WRITE  = 4'h1,
    OP_JMP    = 4'h2,
    OP_BRANCH = 4'h3,
    OP_XOR    = 4'h4,
    OP_SUB    = 4'h5,
    OP_ADD    = 4'h6,
    OP_LESS   = 4'h7,
    OP_INC    = 4'h8,
    OP_DEC    = 4'h9,
    OP_SHL    = 4'hA,
    OP_SHR    = 4'hB,
    OP_BZ     = 4'hC,
    OP_END    = 4'hD
  } opcode_e;

  // Control FSM states.
  typedef enum logic [3:0] {
    ST_IDLE,
    ST_FETCH,
    ST_EXEC,
    ST_LD,
    ST_WRITE,
    ST_ALU,
    ST_JMP,
    ST_BRANCH,
    ST_HALT
  } state_e;

  localparam int NUM_REGS = 4;
  localparam int IR_W     = 16;

  // True for the eight register-to-register ALU opcodes.
  function automatic logic is_alu_op(input logic [3:0] op);
    return (op >= OP_XOR) && (op <= OP_SHR);
  endfunction

endpackage

// File: rtl/nano_cpu_gen_reg_n.sv
// Generic W-bit register with load enable and asynchronous active-high
// reset to zero. Used for the PC, the IR, each general register and zflag.
module reg_n #(
  parameter int W = 8
) (
  input  logic         ck,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Load on enable, clear on reset.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge ck or posedge rst) begin
    if (rst)     q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/nano_cpu_gen.sv
// Multi-cycle accumulator-less CPU: FETCH, EXEC, then one execution state
// per instruction class. Memory accesses (fetch, load, store) stall on
// ready; all architectural updates happen in the exit cycle of a state.
module nano_cpu_gen
  import nano_cpu_gen_pkg::*;
#(
  parameter int DW      = 16,
  parameter int AW      = 8,
  parameter int WAIT_EN = 1
) (
  input  logic          ck,
  input  logic          rst,
  output logic [AW-1:0] address,
  input  logic [DW-1:0] dataR,
  output logic [DW-1:0] dataW,
  output logic          ce,
  output logic          we,
  input  logic          ready,
  output logic          halted,
  output logic          zflag
);

  state_e state, state_nx;

  logic [AW-1:0]   pc, pc_nx;
  logic            pc_en;
  logic [IR_W-1:0] ir;
  logic            ir_en;
  logic [DW-1:0]   regs [NUM_REGS];
  logic [3:0]      reg_en;
  logic [DW-1:0]   reg_wd;
  logic            z_en, z_d;
  logic [DW-1:0]   alu_y;
  logic            rdy;

  // Instruction fields.
  logic [3:0]    op;
  logic [AW-1:0] addr_f;
  logic [1:0]    rd, rs1, rs2;
  logic [DW-1:0] a, b;

  assign op     = ir[15:12];
  assign addr_f = ir[AW+3:4];
  assign rd     = ir[9:8];
  assign rs1    = ir[5:4];
  assign rs2    = ir[1:0];
  assign a      = regs[rs1];
  assign b      = regs[rs2];
  assign rdy    = (WAIT_EN != 0) ? ready : 1'b1;

  // Only part of IR is decoded for small AW, and only dataR[15:0] feeds IR.
  logic unused;
  assign unused = ^{ir, dataR};

  // Architectural registers.
  reg_n #(.W(AW))   u_pc (.ck(ck), .rst(rst), .en(pc_en), .d(pc_nx),           .q(pc));
  reg_n #(.W(IR_W)) u_ir (.ck(ck), .rst(rst), .en(ir_en), .d(dataR[IR_W-1:0]), .q(ir));
  reg_n #(.W(1))    u_z  (.ck(ck), .rst(rst), .en(z_en),  .d(z_d),             .q(zflag));

  // NOTE: the register file is reset like any other flop because software may read it before writing.
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_rf
    reg_n #(.W(DW)) u_r (.ck(ck), .rst(rst), .en(reg_en[i]), .d(reg_wd), .q(regs[i]));
  end

  // ALU; for WRITE it passes reg[rs2] through so dataW always equals alu_y.
  always_comb begin
    alu_y = b;
    case (op)
      OP_XOR:  alu_y = a ^ b;
      OP_SUB:  alu_y = a - b;
      OP_ADD:  alu_y = a + b;
      OP_LESS: alu_y = (a < b) ? DW'(1) : '0;
      OP_INC:  alu_y = a + DW'(1);
      OP_DEC:  alu_y = a - DW'(1);
      OP_SHL:  alu_y = a << b[3:0];
      OP_SHR:  alu_y = a >> b[3:0];
      default: alu_y = b;
    endcase
  end

  assign z_d = (alu_y == '0);

  // State register.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // Next-state and register-enable decode.
  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nx = state;
    pc_en    = 1'b0;
    pc_nx    = pc + AW'(1);
    ir_en    = 1'b0;
    reg_en   = '0;
    reg_wd   = alu_y;
    z_en     = 1'b0;
    case (state)
      ST_IDLE: state_nx = ST_FETCH;
      ST_FETCH: begin
        if (rdy) begin
          ir_en    = 1'b1;
          state_nx = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (op == OP_READ)                       state_nx = ST_LD;
        else if (op == OP_WRITE)                 state_nx = ST_WRITE;
        else if (op == OP_JMP)                   state_nx = ST_JMP;
        else if (op == OP_BRANCH || op == OP_BZ) state_nx = ST_BRANCH;
        else if (is_alu_op(op))                  state_nx = ST_ALU;
        else begin
          // END has no execution state, so PC steps past it on the way to HALT.
          state_nx = ST_HALT;
          pc_en    = 1'b1;
        end
      end
      ST_LD: begin
        if (rdy) begin
          reg_en[rs2] = 1'b1;
          reg_wd      = dataR;
          pc_en       = 1'b1;
          state_nx    = ST_FETCH;
        end
      end
      ST_WRITE: begin
        if (rdy) begin
          pc_en    = 1'b1;
          state_nx = ST_FETCH;
        end
      end
      ST_ALU: begin
        reg_en[rd] = 1'b1;
        z_en       = 1'b1;
        pc_en      = 1'b1;
        state_nx   = ST_FETCH;
      end
      ST_JMP: begin
        pc_nx    = addr_f;
        pc_en    = 1'b1;
        state_nx = ST_FETCH;
      end
      ST_BRANCH: begin
        if ((op == OP_BZ) ? zflag : b[0]) pc_nx = addr_f;
        pc_en    = 1'b1;
        state_nx = ST_FETCH;
      end
      ST_HALT: state_nx = ST_HALT;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Memory interface; all terms are held constant while a state waits on ready.
  assign address = (state == ST_FETCH) ? pc : addr_f;
  assign dataW   = alu_y;
  assign ce      = (state == ST_FETCH) || (state == ST_LD) || (state == ST_WRITE);
  assign we      = (state == ST_WRITE);
  assign halted  = (state == ST_HALT);

endmodule

// File: tb/tb_nano_cpu_gen.sv
// Bench for nano_cpu_gen: directed scenarios plus random programs checked
// against an instruction-level interpreter of the ISA.
module tb_nano_cpu_gen;

  localparam int DW = 16;
  localparam int AW = 8;

  logic ck = 1'b0;
  logic rst = 1'b1;
  always #5 ck = ~ck;

  // Main DUT (AW=8, waits honoured).
  logic [AW-1:0] address;
  logic [DW-1:0] dataR, dataW;
  logic          ce, we, ready, halted, zflag;
  // Second DUT (AW=4, ready ignored and tied low).
  logic [3:0]    address4;
  logic [DW-1:0] dataR4, dataW4;
  logic          ce4, we4, halted4, zflag4;

  logic [DW-1:0] img  [256];
  logic [DW-1:0] mem  [256];
  logic [DW-1:0] img4 [16];
  logic [DW-1:0] mem4 [16];
  logic [23:0]   got_wr [$];

  // Model state.
  logic [DW-1:0] mimg [256];
  logic [23:0]   exp_wr [$];
  logic [DW-1:0] exp_r [4];
  logic          exp_z;
  int            exp_pc;

  int n_checks = 0;
  int n_pass   = 0;

  nano_cpu_gen #(.DW(DW), .AW(AW), .WAIT_EN(1)) dut (
    .ck(ck), .rst(rst), .address(address), .dataR(dataR), .dataW(dataW),
    .ce(ce), .we(we), .ready(ready), .halted(halted), .zflag(zflag)
  );

  nano_cpu_gen #(.DW(DW), .AW(4), .WAIT_EN(0)) dut4 (
    .ck(ck), .rst(rst), .address(address4), .dataR(dataR4), .dataW(dataW4),
    .ce(ce4), .we(we4), .ready(1'b0), .halted(halted4), .zflag(zflag4)
  );

  assign dataR  = mem[address];
  assign dataR4 = mem4[address4];

  // Memories: loaded from the image during reset, written on accepted stores.
  always @(posedge ck) begin
    if (rst) begin
      mem <= img;
      got_wr.delete();
    end else if (ce && we && ready) begin
      mem[address] <= dataW;
      got_wr.push_back({address, dataW});
    end
  end

  always @(posedge ck) begin
    if (rst)             mem4 <= img4;
    else if (ce4 && we4) mem4[address4] <= dataW4;
  end

  function automatic logic [15:0] enc_mem(input logic [3:0] op, input logic [7:0] adr, input logic [1:0] r);
    return {op, adr, 2'b00, r};
  endfunction

  function automatic logic [15:0] enc_alu(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                                          input logic [1:0] rs2);
    return {op, 2'b00, rd, 2'b00, rs1, 2'b00, rs2};
  endfunction

  // Instruction-level interpreter: runs mimg from PC 0 until END.
  task automatic model_run(input int aw);
    logic [DW-1:0] m [256];
    logic [DW-1:0] x, y, res;
    logic [15:0]   ir;
    int amask, pc, adr, op;
    bit done;
    m = mimg;
    amask = (1 << aw) - 1;
    pc = 0; exp_z = 1'b0; done = 0;
    for (int i = 0; i < 4; i++) exp_r[i] = '0;
    exp_wr.delete();
    for (int s = 0; s < 4000 && !done; s++) begin
      ir  = m[pc];
      op  = int'(ir[15:12]);
      adr = int'(ir[11:4]) & amask;
      x   = exp_r[ir[5:4]];
      y   = exp_r[ir[1:0]];
      if (op == 0) begin
        exp_r[ir[1:0]] = m[adr]; pc = (pc + 1) & amask;
      end else if (op == 1) begin
        m[adr] = y; exp_wr.push_back({8'(adr), y}); pc = (pc + 1) & amask;
      end else if (op == 2) begin
        pc = adr;
      end else if (op == 3 || op == 12) begin
        pc = ((op == 3) ? y[0] : exp_z) ? adr : ((pc + 1) & amask);
      end else if (op <= 11) begin
        case (op)
          4:  res = x ^ y;
          5:  res = x - y;
          6:  res = x + y;
          7:  res = (x < y) ? 16'd1 : 16'd0;
          8:  res = x + 16'd1;
          9:  res = x - 16'd1;
          10: res = x << y[3:0];
          default: res = x >> y[3:0];
        endcase
        exp_r[ir[9:8]] = res; exp_z = (res == 16'd0); pc = (pc + 1) & amask;
      end else begin
        pc = (pc + 1) & amask; done = 1;
      end
    end
    exp_pc = pc;
  endtask

  task automatic do_reset();
    rst = 1'b1; ready = 1'b1;
    repeat (2) @(negedge ck);
    rst = 1'b0;
  endtask

  task automatic run_to_halt(input int pct, input int max_cycles, input string tag);
    int c = 0;
    while (halted !== 1'b1 && c < max_cycles) begin
      @(negedge ck);
      ready = (int'($urandom_range(0, 99)) < pct);
      c++;
    end
    ready = 1'b1;
    n_checks++;
    if (halted !== 1'b1) $display("FAIL %s_halt: halted=%b after %0d cycles, required 1", tag, halted, c);
    else n_pass++;
  endtask

  task automatic check_model(input string tag);
    n_checks++;
    if (got_wr.size() != exp_wr.size())
      $display("FAIL %s_nwrites: got %0d required %0d", tag, got_wr.size(), exp_wr.size());
    else n_pass++;
    for (int i = 0; i < exp_wr.size() && i < got_wr.size(); i++) begin
      n_checks++;
      if (got_wr[i] !== exp_wr[i]) $display("FAIL %s_write%0d: got %h required %h", tag, i, got_wr[i], exp_wr[i]);
      else n_pass++;
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (dut.regs[i] !== exp_r[i]) $display("FAIL %s_r%0d: got %h required %h", tag, i, dut.regs[i], exp_r[i]);
      else n_pass++;
    end
    n_checks++;
    if (zflag !== exp_z || dut.pc !== 8'(exp_pc) || ce !== 1'b0 || we !== 1'b0)
      $display("FAIL %s_final: z=%b pc=%h ce=%b we=%b required z=%b pc=%h ce=0 we=0",
               tag, zflag, dut.pc, ce, we, exp_z, 8'(exp_pc));
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1; ready = 1'b1;
    repeat (2) @(negedge ck);
    n_checks++;
    if (ce !== 1'b0 || we !== 1'b0 || halted !== 1'b0 || zflag !== 1'b0 || dut.pc !== 8'h00 || dut.ir !== 16'h0)
      $display("FAIL reset_outputs: ce=%b we=%b halted=%b z=%b pc=%h ir=%h required all 0",
               ce, we, halted, zflag, dut.pc, dut.ir);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (dut.regs[i] !== 16'h0) $display("FAIL reset_r%0d: got %h required 0000", i, dut.regs[i]);
      else n_pass++;
    end
  endtask

  task automatic test_ld_wait();
    bit found = 0;
    foreach (img[i]) img[i] = '0;
    img[0] = enc_mem(4'h0, 8'h10, 2'd1);
    img[1] = 16'hD000;
    img[8'h10] = 16'h1234;
    do_reset();
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge ck);
      found = (ce === 1'b1 && address === 8'h10);
    end
    n_checks++;
    if (!found) $display("FAIL ld_reach: load access at 10 not seen, address=%h required 10", address);
    else n_pass++;
    ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge ck);
      n_checks++;
      if (address !== 8'h10 || ce !== 1'b1 || we !== 1'b0 || dut.regs[1] !== 16'h0 || dut.pc !== 8'h00)
        $display("FAIL ld_stall%0d: addr=%h ce=%b we=%b r1=%h pc=%h required 10 1 0 0000 00",
                 k, address, ce, we, dut.regs[1], dut.pc);
      else n_pass++;
    end
    ready = 1'b1;
    @(negedge ck);
    n_checks++;
    if (dut.regs[1] !== 16'h1234 || dut.pc !== 8'h01 || address !== 8'h01 || ce !== 1'b1)
      $display("FAIL ld_done: r1=%h pc=%h addr=%h ce=%b required 1234 01 01 1", dut.regs[1], dut.pc, address, ce);
    else n_pass++;
    run_to_halt(100, 50, "ld");
  endtask

  task automatic test_alu_zflag();
    foreach (img[i]) img[i] = '0;
    img[0] = enc_mem(4'h0, 8'h80, 2'd0);
    img[1] = enc_mem(4'h0, 8'h81, 2'd1);
    img[2] = enc_alu(4'h6, 2'd2, 2'd0, 2'd1);
    img[3] = 16'hD000;
    img[8'h80] = 16'hFFFF;
    img[8'h81] = 16'h0001;
    do_reset();
    run_to_halt(100, 100, "add");
    n_checks++;
    if (dut.regs[2] !== 16'h0000 || zflag !== 1'b1)
      $display("FAIL add_wrap: r2=%h z=%b required 0000 1", dut.regs[2], zflag);
    else n_pass++;
    img[3] = enc_alu(4'h8, 2'd3, 2'd1, 2'd0);
    img[4] = 16'hD000;
    do_reset();
    run_to_halt(100, 100, "inc");
    n_checks++;
    if (dut.regs[3] !== 16'h0002 || zflag !== 1'b0 || dut.regs[2] !== 16'h0000)
      $display("FAIL inc: r3=%h z=%b r2=%h required 0002 0 0000", dut.regs[3], zflag, dut.regs[2]);
    else n_pass++;
  endtask

  task automatic test_write();
    foreach (img[i]) img[i] = '0;
    img[0] = enc_mem(4'h0, 8'h80, 2'd2);
    img[1] = enc_mem(4'h1, 8'h20, 2'd2);
    img[2] = 16'hD000;
    img[8'h80] = 16'hBEEF;
    do_reset();
    run_to_halt(100, 100, "write");
    n_checks++;
    if (got_wr.size() != 1 || got_wr[0] !== {8'h20, 16'hBEEF})
      $display("FAIL write_pulse: writes=%0d first=%h required 1 20beef", got_wr.size(),
               (got_wr.size() > 0) ? got_wr[0] : 24'h0);
    else n_pass++;
    n_checks++;
    if (dut.regs[2] !== 16'hBEEF || dut.regs[0] !== 16'h0 || dut.regs[1] !== 16'h0 || dut.regs[3] !== 16'h0
        || zflag !== 1'b0)
      $display("FAIL write_regs: r0..r3=%h %h %h %h z=%b required 0000 0000 beef 0000 0",
               dut.regs[0], dut.regs[1], dut.regs[2], dut.regs[3], zflag);
    else n_pass++;
  endtask

  task automatic test_branch();
    foreach (img[i]) img[i] = '0;
    img[0] = enc_mem(4'h0, 8'h80, 2'd2);
    img[1] = enc_mem(4'h3, 8'h30, 2'd2);
    img[2] = enc_mem(4'h0, 8'h81, 2'd3);
    img[3] = enc_mem(4'h3, 8'h30, 2'd3);
    img[4] = enc_mem(4'h1, 8'hC0, 2'd3);
    img[5] = 16'hD000;
    img[8'h30] = enc_alu(4'h5, 2'd0, 2'd3, 2'd3);
    img[8'h31] = enc_mem(4'hC, 8'h40, 2'd0);
    img[8'h32] = enc_mem(4'h1, 8'hC1, 2'd3);
    img[8'h33] = 16'hD000;
    img[8'h40] = 16'hD000;
    img[8'h80] = 16'h0002;
    img[8'h81] = 16'h0003;
    do_reset();
    run_to_halt(100, 100, "branch");
    n_checks++;
    if (dut.pc !== 8'h41 || dut.regs[3] !== 16'h0003 || zflag !== 1'b1 || got_wr.size() != 0)
      $display("FAIL branch_path: pc=%h r3=%h z=%b writes=%0d required 41 0003 1 0",
               dut.pc, dut.regs[3], zflag, got_wr.size());
    else n_pass++;
  endtask

  task automatic test_latency();
    int fc [$];
    int hc = -1;
    foreach (img[i]) img[i] = '0;
    for (int i = 0; i < 3; i++) img[i] = enc_alu(4'h8, 2'd0, 2'd0, 2'd0);
    img[3] = 16'hD000;
    do_reset();
    for (int c = 1; c <= 20; c++) begin
      @(negedge ck);
      if (ce === 1'b1) fc.push_back(c);
      if (halted === 1'b1 && hc < 0) hc = c;
    end
    n_checks++;
    if (fc.size() != 4 || fc[0] != 1 || fc[1] != 4 || fc[2] != 7 || fc[3] != 10)
      $display("FAIL latency_fetch: %0d fetches first=%0d last=%0d required 4 at cycles 1,4,7,10",
               fc.size(), (fc.size() > 0) ? fc[0] : -1, (fc.size() > 0) ? fc[fc.size()-1] : -1);
    else n_pass++;
    n_checks++;
    if (hc != 12 || dut.regs[0] !== 16'h0003)
      $display("FAIL latency_halt: halt cycle=%0d r0=%h required 12 0003", hc, dut.regs[0]);
    else n_pass++;
  endtask

  task automatic test_aw4_wrap();
    logic [3:0] fa [$];
    bit ok;
    foreach (img4[i]) img4[i] = '0;
    img4[0]    = 16'hC050;
    img4[1]    = 16'h20F0;
    img4[5]    = 16'hD000;
    img4[4'hF] = enc_alu(4'h6, 2'd0, 2'd0, 2'd0);
    foreach (mimg[i]) mimg[i] = '0;
    for (int i = 0; i < 16; i++) mimg[i] = img4[i];
    model_run(4);
    do_reset();
    for (int c = 0; c < 25; c++) begin
      @(negedge ck);
      if (ce4 === 1'b1) fa.push_back(address4);
    end
    ok = (fa.size() == 5);
    if (ok) ok = (fa[0] == 4'h0 && fa[1] == 4'h1 && fa[2] == 4'hF && fa[3] == 4'h0 && fa[4] == 4'h5);
    n_checks++;
    if (!ok) $display("FAIL aw4_fetch_trace: %0d fetches, required 5 at 0,1,f,0,5", fa.size());
    else n_pass++;
    for (int k = 0; k < 3; k++) begin
      repeat (7) @(negedge ck);
      n_checks++;
      if (halted4 !== 1'b1 || ce4 !== 1'b0 || we4 !== 1'b0 || dut4.pc !== 4'(exp_pc) || dut4.pc !== 4'h6)
        $display("FAIL aw4_halt%0d: halted=%b ce=%b we=%b pc=%h required 1 0 0 6", k, halted4, ce4, we4, dut4.pc);
      else n_pass++;
    end
  endtask

  task automatic test_reset_in_ld();
    bit found = 0;
    foreach (img[i]) img[i] = '0;
    img[0] = enc_mem(4'h0, 8'h81, 2'd2);
    img[1] = enc_mem(4'h0, 8'h80, 2'd1);
    img[2] = 16'hD000;
    img[8'h80] = 16'h5555;
    img[8'h81] = 16'h7777;
    do_reset();
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge ck);
      found = (ce === 1'b1 && address === 8'h80);
    end
    ready = 1'b0;
    repeat (2) @(negedge ck);
    n_checks++;
    if (!found || dut.regs[2] !== 16'h7777 || dut.regs[1] !== 16'h0)
      $display("FAIL rstld_pre: found=%0d r2=%h r1=%h required 1 7777 0000", found, dut.regs[2], dut.regs[1]);
    else n_pass++;
    rst = 1'b1;
    #1;
    n_checks++;
    if (dut.regs[0] !== 16'h0 || dut.regs[1] !== 16'h0 || dut.regs[2] !== 16'h0 || dut.regs[3] !== 16'h0
        || dut.pc !== 8'h00 || ce !== 1'b0 || halted !== 1'b0)
      $display("FAIL rstld_clear: r2=%h pc=%h ce=%b halted=%b required 0000 00 0 0", dut.regs[2], dut.pc, ce, halted);
    else n_pass++;
    @(negedge ck);
    rst = 1'b0; ready = 1'b1;
    @(negedge ck);
    n_checks++;
    if (ce !== 1'b1 || address !== 8'h00) $display("FAIL rstld_refetch: ce=%b addr=%h required 1 00", ce, address);
    else n_pass++;
    run_to_halt(100, 100, "rstld");
  endtask

  task automatic test_random();
    for (int it = 0; it < 25; it++) begin
      int n, k, pct;
      logic [1:0] r;
      foreach (img[i]) img[i] = '0;
      n = $urandom_range(8, 40);
      for (int i = 0; i < n; i++) begin
        k = $urandom_range(0, 11);
        r = 2'($urandom_range(0, 3));
        if (k <= 1)      img[i] = enc_mem(4'h0, 8'($urandom_range(8'h80, 8'hBF)), r);
        else if (k == 2) img[i] = enc_mem(4'h1, 8'($urandom_range(8'hC0, 8'hEF)), r);
        else if (k == 3) img[i] = enc_mem(4'h2, 8'($urandom_range(i + 1, n)), r);
        else if (k == 4) img[i] = enc_mem(4'h3, 8'($urandom_range(i + 1, n)), r);
        else if (k == 5) img[i] = enc_mem(4'hC, 8'($urandom_range(i + 1, n)), r);
        else img[i] = enc_alu(4'($urandom_range(4, 11)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), r);
      end
      img[n] = 16'hD000;
      for (int i = 8'h80; i <= 8'hBF; i++)
        img[i] = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom);
      mimg = img;
      model_run(8);
      pct = $urandom_range(30, 100);
      do_reset();
      run_to_halt(pct, 3000, "rand");
      check_model("rand");
    end
  endtask

  initial begin
    ready = 1'b1;
    foreach (img[i]) img[i] = '0;
    foreach (img4[i]) img4[i] = '0;
    test_reset();
    test_ld_wait();
    test_alu_zflag();
    test_write();
    test_branch();
    test_latency();
    test_aw4_wrap();
    test_reset_in_ld();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
